// File: rtl/stream_pkg.sv
// Shared stream definitions for the mux/demux pair.
// A beat pairs a payload with the channel index it came from or is routed to.
package stream_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic                 sel;
  } beat_t;

endpackage

// File: rtl/stream_mux2_1_if.sv
// Handshake bundle for the 2-to-1 stream mux: two source channels, one tagged
// output channel and the per-channel beat counters.
interface stream_mux2_1_if
  import stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [WIDTH-1:0] in0_data;
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in1_data;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, out_data, out_sel, out_valid, count0, count1
  );

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, out_data, out_sel, out_valid, count0, count1
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; prio names the channel that wins a tie and
// moves only when a grant is actually taken.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic load_ok,
  output logic gnt0,
  output logic gnt1
);

  logic prio;

  always_comb begin
    gnt0 = load_ok && !(req1 && prio);
    gnt1 = load_ok && !(req0 && !prio);
  end

  // A lone requester also moves the pointer, handing the next tie to the other side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (req0 && gnt0) begin
      prio <= 1'b1;
    end else if (req1 && gnt1) begin
      prio <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_mux2_1.sv
// 2-to-1 round-robin stream mux with a single registered output beat tagged by
// source channel, plus wrapping per-channel accepted-beat counters.
module stream_mux2_1
  import stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  stream_mux2_1_if.slave  bus
);

  logic             load_ok;
  logic             gnt0;
  logic             gnt1;
  logic             xfer0;
  logic             xfer1;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  assign load_ok = !valid_q || bus.out_ready;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req0    (bus.in0_valid),
    .req1    (bus.in1_valid),
    .load_ok (load_ok),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign bus.in0_ready = gnt0;
  assign bus.in1_ready = gnt1;
  assign xfer0 = bus.in0_valid && gnt0;
  assign xfer1 = bus.in1_valid && gnt1;

  // A load in the drain cycle overwrites the old beat, keeping valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (xfer0) begin
      data_q  <= bus.in0_data;
      sel_q   <= 1'b0;
      valid_q <= 1'b1;
    end else if (xfer1) begin
      data_q  <= bus.in1_data;
      sel_q   <= 1'b1;
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (xfer0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (xfer1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.count0    = cnt0_q;
  assign bus.count1    = cnt1_q;

endmodule

// File: tb/tb_stream_mux2_1.sv
// Randomised and directed bench for stream_mux2_1 against a queue-based model
// of the held beat, fairness pointer and beat counts.
module tb_stream_mux2_1;
  import stream_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_mux2_1_if #(.WIDTH(16), .CNT_W(8)) bus ();

  stream_mux2_1 #(.WIDTH(16), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: the held beat (0 or 1 entries), tie-winner and beat counts.
  beat_t held_q[$];
  bit    m_prio;
  int    m_cnt0;
  int    m_cnt1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    chk({tag, "_out_valid"}, bus.out_valid, held_q.size() != 0);
    if (held_q.size() != 0) begin
      chk({tag, "_out_data"}, bus.out_data, held_q[0].data);
      chk({tag, "_out_sel"}, bus.out_sel, held_q[0].sel);
    end
    chk({tag, "_count0"}, bus.count0, m_cnt0);
    chk({tag, "_count1"}, bus.count1, m_cnt1);
  endtask

  // Called at posedge+1; drives one cycle of stimulus and checks both sides.
  task automatic cycle(bit v0, logic [15:0] d0, bit v1, logic [15:0] d1, bit ordy);
    bit    load_ok;
    bit    acc;
    bit    w;
    beat_t b;
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.out_ready = ordy;
    load_ok = (held_q.size() == 0) || ordy;
    acc = load_ok && (v0 || v1);
    w   = (v0 && v1) ? m_prio : v1;
    #4;
    chk("in0_ready", bus.in0_ready, load_ok && !(v1 && m_prio));
    chk("in1_ready", bus.in1_ready, load_ok && !(v0 && !m_prio));
    @(posedge clk);
    if (held_q.size() != 0 && ordy) void'(held_q.pop_front());
    if (acc) begin
      b.data = w ? d1 : d0;
      b.sel  = w;
      held_q.push_back(b);
      m_prio = !w;
      if (w) m_cnt1 = (m_cnt1 + 1) % 256;
      else   m_cnt0 = (m_cnt0 + 1) % 256;
    end
    #1;
    check_outputs("cyc");
  endtask

  // Called at posedge+1; pulses reset for one cycle, checking the async clear.
  task automatic do_reset();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    reset = 1'b1;
    #1;
    held_q.delete();
    m_prio = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sel", bus.out_sel, 0);
    chk("rst_in0_ready", bus.in0_ready, 1);
    chk("rst_in1_ready", bus.in1_ready, 1);
    check_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_data  = '0;
    bus.in1_data  = '0;
    bus.out_ready = 1'b0;
    m_prio = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
    #2;
    chk("por_in0_ready", bus.in0_ready, 1);
    chk("por_in1_ready", bus.in1_ready, 1);
    chk("por_out_valid", bus.out_valid, 0);
    chk("por_out_data", bus.out_data, 0);
    chk("por_count0", bus.count0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single beat from ch0.
    cycle(1'b1, 16'hA5A5, 1'b0, 16'h0, 1'b1);
    chk("t1_data", bus.out_data, 16'hA5A5);
    chk("t1_sel", bus.out_sel, 0);
    chk("t1_count0", bus.count0, 1);

    // Both valid every cycle: strict alternation starting with ch0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'h0001 + 16'(i), 1'b1, 16'h1001 + 16'(i), 1'b1);
      chk("alt_sel", bus.out_sel, i % 2);
    end
    chk("alt_count0", bus.count0, 4);
    chk("alt_count1", bus.count1, 4);

    // Lone ch1 for 3 beats, then contention: ch0 then ch1.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 1'b1, 16'h2000 + 16'(i), 1'b1);
      chk("lone_sel", bus.out_sel, 1);
    end
    cycle(1'b1, 16'h3000, 1'b1, 16'h3001, 1'b1);
    chk("cont_sel0", bus.out_sel, 0);
    cycle(1'b1, 16'h3002, 1'b1, 16'h3003, 1'b1);
    chk("cont_sel1", bus.out_sel, 1);

    // Back-pressure with BEEF held for 5 cycles.
    do_reset();
    cycle(1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'h4000 + 16'(i), 1'b1, 16'h5000, 1'b0);
      chk("bp_hold", bus.out_data, 16'hBEEF);
    end
    cycle(1'b1, 16'h4444, 1'b0, 16'h0, 1'b1);
    chk("bp_next", bus.out_data, 16'h4444);

    // Counter wrap after 256 ch0 beats.
    do_reset();
    for (int i = 0; i < 256; i++) cycle(1'b1, 16'(i), 1'b0, 16'h0, 1'b1);
    chk("wrap_count0", bus.count0, 0);
    chk("wrap_count1", bus.count1, 0);

    // Reset while a beat is stalled: beat discarded, pointer back to ch0.
    cycle(1'b1, 16'hCAFE, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    do_reset();
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("rst_no_deliver", bus.out_valid, 0);
    cycle(1'b1, 16'h6000, 1'b1, 16'h6001, 1'b1);
    chk("rst_prio_sel", bus.out_sel, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
            $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux2_1.md
# stream_mux2_1

Two-input, one-output 16-bit stream multiplexer; the merging counterpart of the team's 1-to-2 demultiplexer. It arbitrates round-robin between two valid/ready source channels, registers the winning beat, and presents it on a single output channel tagged with its source index. It sits where two producers share one consumer, so that a later demultiplexer stage can route each beat back out on `out_sel`.

## Interface
- `WIDTH`, 16, data width of all channels
- `CNT_W`, 8, width of the per-channel beat counters
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in0_data`  in  WIDTH  channel 0 payload
- `in0_valid`  in  1  channel 0 beat offered
- `in0_ready`  out  1  channel 0 beat accepted this cycle when `in0_valid` is also high
- `in1_data`  in  WIDTH  channel 1 payload
- `in1_valid`  in  1  channel 1 beat offered
- `in1_ready`  out  1  channel 1 beat accepted this cycle when `in1_valid` is also high
- `out_data`  out  WIDTH  registered payload
- `out_sel`  out  1  source channel of `out_data`
- `out_valid`  out  1  output beat held
- `out_ready`  in  1  consumer accepts the output beat
- `count0`  out  CNT_W  beats accepted from channel 0
- `count1`  out  CNT_W  beats accepted from channel 1

## Operation
- Transfer on any channel means `valid && ready` high at a rising edge.
- Output stage is a single register holding one beat.
  - `load_ok = !out_valid || out_ready`.
- Priority pointer `prio` names the channel that wins when both channels are valid.
- Grant rules:
  - `in0_ready = load_ok && !(in1_valid && prio==1)`.
  - `in1_ready = load_ok && !(in0_valid && prio==0)`.
  - At most one channel transfers per cycle. The case where both `in*_valid` and both `in*_ready` are high cannot occur.
- On a transfer from channel i:
  - `out_data <= in_i_data`, `out_sel <= i`, `out_valid <= 1`.
  - `prio <= !i`.
  - `count_i <= count_i + 1`.
- The pointer changes only on a transfer, so a lone requester does not disturb fairness.
- Output drain without a load (`out_ready && !any transfer`): `out_valid <= 0`. `out_data` and `out_sel` hold their values.
- Drain and load in the same cycle: the new beat replaces the old one and `out_valid` stays 1, giving a bubble-free stream.
- Counters are modulo 2^CNT_W: 255 + 1 = 0, with no saturation or flag.
- `out_data` and `out_sel` are don't-care while `out_valid` = 0, but must not change while `out_valid` = 1 and `out_ready` = 0.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_sel` 0, `prio` 0, `count0` 0, `count1` 0.
  - During reset, `in0_ready` and `in1_ready` evaluate combinationally, so both read 1 when the source valids are 0.
- Latency: input transfer at edge N makes `out_valid` = 1 after edge N.
- Throughput: 1 beat per cycle sustained while `out_ready` = 1.
- Back-pressure: `out_ready` low while `out_valid` is high drops both `in*_ready` in the same cycle, combinationally.
- The ready outputs depend combinationally on `out_ready`, `out_valid`, the other channel's valid, and `prio`. There is no combinational path from `in*_data` to any output.
- Reset asserted mid-stream discards the held beat immediately. Counters and pointer clear asynchronously.

## Structure
- Shared package `stream_pkg`:
  - `WIDTH_DEF` = 16, `CNT_W_DEF` = 8.
  - Typedef for a `{data, sel}` beat, shared with the demultiplexer so that `out_sel` feeds its selector directly.
- Sub-module `rr_arb2`:
  - Inputs: two requests, `load_ok`, `clk`, `reset`.
  - Outputs: two grants.
  - Owns `prio`.
- The parent owns the output register and the counters.

## Test plan
- Reset, then `in0_valid` = 1 with 16'hA5A5 and `out_ready` = 1 → `in0_ready` = 1. Next cycle: `out_data` = A5A5, `out_sel` = 0, `out_valid` = 1, `count0` = 1.
- Both valid every cycle (ch0 = 16'h0001.., ch1 = 16'h1001..) with `out_ready` = 1 → `out_sel` alternates 0,1,0,1. After 8 beats: `count0` = 4, `count1` = 4.
- Only ch1 valid for 3 beats, then both valid → ch1 wins the first 3 beats with `prio` = 0, then ch0 wins, then ch1.
- Hold `out_ready` = 0 with 16'hBEEF held → `out_data` stays BEEF and both readies are 0 for 5 cycles. Raise `out_ready` → the next beat appears one cycle later with no beat lost or duplicated.
- 256 transfers on ch0 → `count0` wraps to 0 and `count1` = 0.
- Assert `reset` while `out_valid` = 1 with `out_ready` = 0 → `out_valid`, counters and `prio` clear immediately, and the held beat is never delivered.
